// File: rtl/dr_pkg.sv
// rtl/dr_pkg.sv - shared encodings and helpers for the data assembly register
//
// Purpose: direct-op select encodings, FSM state type and the helper that
//          locates the sign bit of a partially loaded value.
// Ports:   none (package).

package dr_pkg;

    localparam logic [1:0] OP_SEXT = 2'b00;
    localparam logic [1:0] OP_ZEXT = 2'b01;
    localparam logic [1:0] OP_SHL  = 2'b10;
    localparam logic [1:0] OP_SHR  = 2'b11;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        LOAD = 1'b1
    } dr_state_e;

    // A value of (size+1) beats has its sign in the top bit of the last beat.
    function automatic int sign_bit_idx(input int size, input int beat_w);
        return (size + 1) * beat_w - 1;
    endfunction

endpackage

// File: rtl/dr_extend.sv
// rtl/dr_extend.sv - sign/zero extension of a (size+1)-beat value to full width
//
// Purpose: keeps the low (size_i+1)*BEAT_W bits of val_i and fills everything
//          above with either the sign bit (signed_i=1) or zeros.
// Ports:
//   val_i     in  DATA_W  assembled value (bits above the valid part ignored)
//   size_i    in  SZ_W    number of valid beats minus 1
//   signed_i  in  1       1 = sign-extend, 0 = zero-extend
//   ext_o     out DATA_W  extended word

module dr_extend
    import dr_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int BEAT_W = 8,
    parameter int SZ_W   = 2
) (
    input  logic [DATA_W-1:0] val_i,
    input  logic [SZ_W-1:0]   size_i,
    input  logic              signed_i,
    output logic [DATA_W-1:0] ext_o
);

    localparam int NBEATS = DATA_W / BEAT_W;

    int   top_idx;
    logic sign_bit;
    logic fill;

    always_comb begin
        top_idx  = sign_bit_idx(int'(size_i), BEAT_W);
        // Pick the sign bit with constant indices per beat so the select
        // stays a small mux rather than a variable bit-select.
        sign_bit = 1'b0;
        for (int b = 0; b < NBEATS; b++) begin
            if (size_i == SZ_W'(b)) begin
                sign_bit = val_i[b*BEAT_W + BEAT_W - 1];
            end
        end
        fill  = signed_i & sign_bit;
        ext_o = '0;
        for (int i = 0; i < DATA_W; i++) begin
            ext_o[i] = (i <= top_idx) ? val_i[i] : fill;
        end
    end

endmodule

// File: rtl/data_assembly_register.sv
// rtl/data_assembly_register.sv - DATA_W operand register with direct ops and multi-beat loader
//
// Purpose: holds the datapath operand. Loaded either by one-cycle direct ops
//          on op_in or by a sequencer that collects 1..NBEATS memory beats,
//          assembles them little/big-endian and extends them into dr_out.
// Ports:
//   clk, rst     in   clock, synchronous active-high reset
//   op_en        in   direct-op enable (IDLE only)
//   op_sel       in   direct-op select (OP_SEXT/OP_ZEXT/OP_SHL/OP_SHR)
//   op_in        in   direct-op data, BEAT_W
//   start        in   begin multi-beat load (IDLE only, wins over op_en)
//   size         in   beats to load minus 1
//   signed_ld    in   1 = sign-extend the loaded value
//   big_endian   in   1 = first beat is most significant
//   abort        in   cancel a load in progress
//   beat_valid   in   memory beat available
//   beat_data    in   memory beat, BEAT_W
//   beat_ready   out  block accepts beats (LOAD)
//   busy         out  load in progress (LOAD)
//   done         out  one-cycle pulse after the final beat
//   dr_out       out  register contents, DATA_W

module data_assembly_register
    import dr_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int BEAT_W = 8,
    localparam int NBEATS = DATA_W / BEAT_W,
    localparam int SZ_W   = $clog2(NBEATS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              op_en,
    input  logic [1:0]        op_sel,
    input  logic [BEAT_W-1:0] op_in,
    input  logic              start,
    input  logic [SZ_W-1:0]   size,
    input  logic              signed_ld,
    input  logic              big_endian,
    input  logic              abort,
    input  logic              beat_valid,
    input  logic [BEAT_W-1:0] beat_data,
    output logic              beat_ready,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] dr_out
);

    dr_state_e         state_q, state_d;
    logic [DATA_W-1:0] dr_q, dr_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [SZ_W-1:0]   cnt_q, cnt_d;
    logic [SZ_W-1:0]   size_q, size_d;
    logic              signed_q, signed_d;
    logic              be_q, be_d;
    logic              done_q, done_d;

    logic [DATA_W-1:0] acc_next;
    logic [DATA_W-1:0] ld_ext;
    logic [DATA_W-1:0] op_ext;
    logic              beat_hs;

    assign beat_ready = (state_q == LOAD);
    assign busy       = (state_q == LOAD);
    assign done       = done_q;
    assign dr_out     = dr_q;
    assign beat_hs    = beat_ready & beat_valid;

    // Accumulator including the beat on the bus this cycle, so the final
    // beat can be extended straight into dr_out at the same edge.
    always_comb begin
        acc_next = acc_q;
        if (be_q) begin
            acc_next = {acc_q[DATA_W-BEAT_W-1:0], beat_data};
        end else begin
            for (int b = 0; b < NBEATS; b++) begin
                if (cnt_q == SZ_W'(b)) begin
                    acc_next[b*BEAT_W +: BEAT_W] = beat_data;
                end
            end
        end
    end

    dr_extend #(
        .DATA_W (DATA_W),
        .BEAT_W (BEAT_W),
        .SZ_W   (SZ_W)
    ) u_ld_ext (
        .val_i    (acc_next),
        .size_i   (size_q),
        .signed_i (signed_q),
        .ext_o    (ld_ext)
    );

    // Direct sign/zero-extend is the one-beat case of the load extender.
    dr_extend #(
        .DATA_W (DATA_W),
        .BEAT_W (BEAT_W),
        .SZ_W   (SZ_W)
    ) u_op_ext (
        .val_i    (DATA_W'(op_in)),
        .size_i   ('0),
        .signed_i (op_sel == OP_SEXT),
        .ext_o    (op_ext)
    );

    always_comb begin
        state_d  = state_q;
        dr_d     = dr_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        size_d   = size_q;
        signed_d = signed_q;
        be_d     = be_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    size_d   = size;
                    signed_d = signed_ld;
                    be_d     = big_endian;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = LOAD;
                end else if (op_en) begin
                    case (op_sel)
                        OP_SEXT, OP_ZEXT: dr_d = op_ext;
                        OP_SHL:           dr_d = {dr_q[DATA_W-BEAT_W-1:0], op_in};
                        OP_SHR:           dr_d = {op_in, dr_q[DATA_W-1:BEAT_W]};
                        default:          dr_d = dr_q;
                    endcase
                end
            end
            LOAD: begin
                // abort beats a coincident final beat: nothing is committed.
                if (abort) begin
                    state_d = IDLE;
                end else if (beat_hs) begin
                    acc_d = acc_next;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == size_q) begin
                        dr_d    = ld_ext;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            dr_q     <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            size_q   <= '0;
            signed_q <= 1'b0;
            be_q     <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            dr_q     <= dr_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            be_q     <= be_d;
            done_q   <= done_d;
        end
    end

endmodule

// File: tb/tb_data_assembly_register.sv
// tb/tb_data_assembly_register.sv - directed self-checking bench for data_assembly_register

module tb_data_assembly_register;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_en;
    logic [1:0]  op_sel;
    logic [7:0]  op_in;
    logic        start;
    logic [1:0]  size;
    logic        signed_ld;
    logic        big_endian;
    logic        abort;
    logic        beat_valid;
    logic [7:0]  beat_data;
    logic        beat_ready;
    logic        busy;
    logic        done;
    logic [31:0] dr_out;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    data_assembly_register #(.DATA_W(32), .BEAT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .op_en      (op_en),
        .op_sel     (op_sel),
        .op_in      (op_in),
        .start      (start),
        .size       (size),
        .signed_ld  (signed_ld),
        .big_endian (big_endian),
        .abort      (abort),
        .beat_valid (beat_valid),
        .beat_data  (beat_data),
        .beat_ready (beat_ready),
        .busy       (busy),
        .done       (done),
        .dr_out     (dr_out)
    );

    typedef struct {
        logic [1:0]  sel;
        logic [7:0]  din;
        logic [31:0] exp;
    } op_vec_t;

    op_vec_t vt[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Full load; beats[8k+:8] is the k-th beat on the bus.
    task automatic do_load(input string nm, input logic [1:0] sz, input logic sgn,
                           input logic be, input logic [31:0] beats, input int stalls,
                           input logic [31:0] exp);
        logic [31:0] old;
        old        = dr_out;
        start      = 1'b1;
        size       = sz;
        signed_ld  = sgn;
        big_endian = be;
        tick();
        start = 1'b0;
        chk({nm, " busy"}, {31'd0, busy}, 32'd1);
        for (int k = 0; k <= int'(sz); k++) begin
            for (int s = 0; s < stalls; s++) begin
                beat_valid = 1'b0;
                tick();
                chk({nm, " stall busy"}, {31'd0, busy}, 32'd1);
            end
            chk({nm, " ready"}, {31'd0, beat_ready}, 32'd1);
            beat_valid = 1'b1;
            beat_data  = beats[8*k +: 8];
            tick();
            beat_valid = 1'b0;
            if (k != int'(sz)) begin
                chk({nm, " early done"}, {31'd0, done}, 32'd0);
                chk({nm, " dr held"}, dr_out, old);
            end
        end
        chk({nm, " done"}, {31'd0, done}, 32'd1);
        chk({nm, " dr_out"}, dr_out, exp);
        chk({nm, " idle"}, {31'd0, busy}, 32'd0);
        tick();
        chk({nm, " done pulse"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; op_en = 1'b0; op_sel = 2'b00; op_in = 8'h00; start = 1'b0;
        size = 2'd0; signed_ld = 1'b0; big_endian = 1'b0; abort = 1'b0;
        beat_valid = 1'b0; beat_data = 8'h00;
        tick();
        tick();
        rst = 1'b0;
        chk("reset dr_out", dr_out, 32'h0);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset ready", {31'd0, beat_ready}, 32'd0);
        chk("reset done", {31'd0, done}, 32'd0);

        // Reset in the middle of a load.
        do_load("le word", 2'd3, 1'b0, 1'b0, 32'hDEADBEEF, 0, 32'hDEADBEEF);
        start = 1'b1; size = 2'd3; signed_ld = 1'b0; big_endian = 1'b0;
        tick();
        start = 1'b0;
        beat_valid = 1'b1; beat_data = 8'hAA; tick();
        beat_data = 8'hBB; tick();
        beat_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst dr_out", dr_out, 32'h0);
        chk("midrst busy", {31'd0, busy}, 32'd0);
        chk("midrst ready", {31'd0, beat_ready}, 32'd0);
        chk("midrst done", {31'd0, done}, 32'd0);

        // Big-endian word with two stall cycles before each beat.
        do_load("be stall", 2'd3, 1'b0, 1'b1, 32'h78563412, 2, 32'h12345678);

        // Direct ops: build 0x11223344, then the four listed ops.
        vt[0] = '{2'b10, 8'h11, 32'h34567811};
        vt[1] = '{2'b10, 8'h22, 32'h56781122};
        vt[2] = '{2'b10, 8'h33, 32'h78112233};
        vt[3] = '{2'b10, 8'h44, 32'h11223344};
        vt[4] = '{2'b00, 8'h80, 32'hFFFFFF80};
        vt[5] = '{2'b01, 8'h80, 32'h00000080};
        vt[6] = '{2'b10, 8'hAB, 32'h000080AB};
        vt[7] = '{2'b11, 8'hCD, 32'hCD000080};
        for (int i = 0; i < 8; i++) begin
            op_en = 1'b1; op_sel = vt[i].sel; op_in = vt[i].din;
            tick();
            op_en = 1'b0;
            chk($sformatf("op vec %0d", i), dr_out, vt[i].exp);
            chk($sformatf("op vec %0d done", i), {31'd0, done}, 32'd0);
        end

        // Little-endian half, signed and unsigned.
        do_load("le half s", 2'd1, 1'b1, 1'b0, 32'h00009234, 0, 32'hFFFF9234);
        do_load("le half u", 2'd1, 1'b0, 1'b0, 32'h00009234, 0, 32'h00009234);

        // Abort after one beat.
        do_load("le cafe", 2'd3, 1'b0, 1'b0, 32'hCAFEF00D, 0, 32'hCAFEF00D);
        start = 1'b1; size = 2'd3; signed_ld = 1'b1; big_endian = 1'b0;
        tick();
        start = 1'b0;
        beat_valid = 1'b1; beat_data = 8'h01; tick();
        beat_valid = 1'b0; abort = 1'b1; tick();
        abort = 1'b0;
        chk("abort busy", {31'd0, busy}, 32'd0);
        chk("abort done", {31'd0, done}, 32'd0);
        chk("abort dr_out", dr_out, 32'hCAFEF00D);
        tick();
        chk("abort done later", {31'd0, done}, 32'd0);

        // Abort coinciding with the final beat.
        start = 1'b1; size = 2'd0; signed_ld = 1'b0; big_endian = 1'b0;
        tick();
        start = 1'b0;
        beat_valid = 1'b1; beat_data = 8'h55; abort = 1'b1;
        tick();
        beat_valid = 1'b0; abort = 1'b0;
        chk("abort last busy", {31'd0, busy}, 32'd0);
        chk("abort last done", {31'd0, done}, 32'd0);
        chk("abort last dr_out", dr_out, 32'hCAFEF00D);
        tick();
        chk("abort last done later", {31'd0, done}, 32'd0);

        // start and op_en while busy are ignored; start in done cycle accepted.
        start = 1'b1; size = 2'd1; signed_ld = 1'b0; big_endian = 1'b0;
        tick();
        start = 1'b1; size = 2'd0; signed_ld = 1'b1; big_endian = 1'b1;
        op_en = 1'b1; op_sel = 2'b00; op_in = 8'hFF;
        beat_valid = 1'b1; beat_data = 8'h81;
        tick();
        start = 1'b0; op_en = 1'b0;
        chk("busy ign still busy", {31'd0, busy}, 32'd1);
        chk("busy ign done", {31'd0, done}, 32'd0);
        chk("busy ign dr_out", dr_out, 32'hCAFEF00D);
        beat_data = 8'h92;
        tick();
        beat_valid = 1'b0;
        chk("busy ign final done", {31'd0, done}, 32'd1);
        chk("busy ign final dr_out", dr_out, 32'h00009281);
        start = 1'b1; size = 2'd0; signed_ld = 1'b1; big_endian = 1'b1;
        tick();
        start = 1'b0;
        chk("b2b busy", {31'd0, busy}, 32'd1);
        beat_valid = 1'b1; beat_data = 8'hF0;
        tick();
        beat_valid = 1'b0;
        chk("b2b done", {31'd0, done}, 32'd1);
        chk("b2b dr_out", dr_out, 32'hFFFFFFF0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/data_assembly_register.md
Name: data_assembly_register

Overview:
- Parametrised successor to the 32-bit byte-fed data register. Holds a DATA_W-bit operand for the datapath.
- Two ways to load it:
  - Direct one-cycle ops on a BEAT_W-bit input: sign-extend, zero-extend, shift-left-load, shift-right-load.
  - Multi-beat load sequencer. It pulls 1..NBEATS beats from the memory side over a valid/ready handshake, assembles them little- or big-endian, then sign- or zero-extends the result into the register.
- Sits between the memory data bus and the ALU/address register file.

Parameters:
- DATA_W, 32, register width; must be an integer multiple of BEAT_W.
- BEAT_W, 8, memory beat width.
- NBEATS (derived, localparam), DATA_W/BEAT_W; must be a power of two and at least 2.
- SZ_W (derived, localparam), clog2(NBEATS), width of size field.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- op_en  in  1  direct-op enable (honoured only in IDLE)
- op_sel  in  2  direct-op select
- op_in  in  BEAT_W  direct-op data
- start  in  1  begin multi-beat load (honoured only in IDLE)
- size  in  SZ_W  beats to load minus 1
- signed_ld  in  1  1 = sign-extend, 0 = zero-extend
- big_endian  in  1  1 = first beat is most significant
- abort  in  1  cancel an in-progress load
- beat_valid  in  1  memory beat available
- beat_data  in  BEAT_W  memory beat
- beat_ready  out  1  block accepts beat
- busy  out  1  load in progress
- done  out  1  one-cycle pulse: load completed, dr_out updated
- dr_out  out  DATA_W  register contents

Behaviour:
- Reset: state IDLE; dr_out, accumulator and beat counter all 0; busy, beat_ready and done all 0. Reset overrides every other input, including in the middle of a load.
- FSM states: IDLE, LOAD. busy = (state==LOAD). beat_ready = (state==LOAD). Both are decoded from registered state.
- IDLE:
  - On start, latch size, signed_ld and big_endian; clear accumulator and counter; go to LOAD.
  - If start and op_en are asserted together, start wins and the op is dropped.
- Direct ops (IDLE, op_en=1, start=0), result in dr_out at the next edge, no done pulse:
  - 00: sign-extend op_in to DATA_W.
  - 01: zero-extend op_in.
  - 10: dr_out <= {dr_out[DATA_W-BEAT_W-1:0], op_in}.
  - 11: dr_out <= {op_in, dr_out[DATA_W-1:BEAT_W]}.
- op_en while busy: ignored. start while busy: ignored, latched fields unchanged.
- LOAD: a beat is accepted only on a cycle where beat_valid and beat_ready are both 1. Stall cycles (valid=0) change nothing.
  - Little-endian: acc[cnt*BEAT_W +: BEAT_W] <= beat_data.
  - Big-endian: acc <= (acc << BEAT_W) | beat_data.
  - cnt increments on each accepted beat.
- Final beat (handshake with cnt==size_q), all at the same edge:
  - Assembled value V holds (size_q+1)*BEAT_W valid low bits.
  - dr_out <= extend(V), using bit (size_q+1)*BEAT_W-1 as the sign bit when signed_ld_q=1, else zero-fill.
  - state goes to IDLE.
  - done goes to 1 for exactly the next cycle.
- Latency: dr_out and done become visible the cycle after the last handshake. Minimum load = 1 start cycle + (size+1) beat cycles.
- dr_out holds its old value for the whole load; the accumulator is separate.
- Back-to-back: start may be asserted in the done cycle (state is already IDLE) and is accepted.
- abort in LOAD: go to IDLE next edge, dr_out unchanged, no done. If abort coincides with the final beat handshake, abort wins. abort in IDLE has no effect.
- size = NBEATS-1 gives a full-width load; extension is then a no-op.

Decomposition:
- Shared package dr_pkg holds:
  - op_sel encodings OP_SEXT=2'b00, OP_ZEXT=2'b01, OP_SHL=2'b10, OP_SHR=2'b11;
  - state enum {IDLE, LOAD};
  - helper function for the size-dependent sign-bit index.
- One combinational sub-module, dr_extend: takes the assembled value, size and signed flag, returns the extended DATA_W word. It is reused by the op path for OP_SEXT and OP_ZEXT with size=0.

Test Plan (defaults DATA_W=32, BEAT_W=8):
- rst mid-load after 2 of 4 beats with dr_out=0xDEADBEEF -> dr_out=0, busy=0, beat_ready=0, done=0. A following 4-beat load completes normally.
- Direct ops from dr_out=0x11223344:
  - op_in=0x80, OP_SEXT -> 0xFFFFFF80.
  - then OP_ZEXT 0x80 -> 0x00000080.
  - then OP_SHL 0xAB -> 0x000080AB.
  - then OP_SHR 0xCD -> 0xCD000080.
- Little-endian signed half (size=1), beats 0x34, 0x92 -> dr_out=0xFFFF9234, one-cycle done pulse the cycle after the 2nd beat. Same with signed_ld=0 -> 0x00009234.
- Big-endian word (size=3), beats 0x12, 0x34, 0x56, 0x78 with beat_valid low for 2 cycles between beats -> dr_out=0x12345678. Stalls do not advance cnt.
- abort after 1 beat of a size=3 load, with dr_out=0xCAFEF00D -> returns to IDLE, dr_out stays 0xCAFEF00D, no done pulse. Separately: abort together with the final beat -> no update.
- start while busy (new size=0) and op_en while busy -> both ignored, original load finishes with the original size. Then start in the done cycle -> accepted, busy=1 next cycle.
